// File: rtl/timer_disp_ctrl.sv
// MM:SS countdown-timer controller feeding the multiplexed seven-segment scanner.
// Holds an editable BCD preset and a running BCD count; outputs digits, enables and alarm.
module timer_disp_ctrl #(
  parameter int unsigned SEC_DIV   = 100_000_000,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_set,
  input  logic       btn_start,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] ONES,
  output logic [3:0] TENS,
  output logic [3:0] HUNDREDS,
  output logic [3:0] THOUSANDS,
  output logic       blink_o,
  output logic       blink_t,
  output logic       blink_h,
  output logic       blink_th,
  output logic       alarm,
  output logic [2:0] state_o
);

  localparam int unsigned SW = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SEC_MAX = SW'(SEC_DIV - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EDIT  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           r_state, w_next_state;
  logic [3:0][3:0]  r_p, r_c;
  logic [1:0]       r_sel;
  logic             r_phase;
  logic [SW-1:0]    r_sec;
  logic [BW-1:0]    r_blk;

  logic w_set, w_start, w_next, w_up, w_down, w_any;
  logic w_p_zero, w_c_one, w_tick, w_load;
  logic [3:0] w_max;

  // Only the highest-priority pulse acts: set > start > next > up > down.
  assign w_set   = btn_set;
  assign w_start = btn_start & ~btn_set;
  assign w_next  = btn_next  & ~btn_set & ~btn_start;
  assign w_up    = btn_up    & ~btn_set & ~btn_start & ~btn_next;
  assign w_down  = btn_down  & ~btn_set & ~btn_start & ~btn_next & ~btn_up;
  assign w_any   = btn_set | btn_start | btn_next | btn_up | btn_down;

  assign w_p_zero = (r_p == '0);
  assign w_c_one  = (r_c == 16'h0001);
  assign w_max    = (r_sel == 2'd1) ? 4'd5 : 4'd9;
  assign w_load   = ((r_state == IDLE) || (r_state == EDIT)) && w_start && !w_p_zero;
  // A button acting on the tick cycle wins; the counter then stays at its max.
  assign w_tick   = (r_state == RUN) && (r_sec == SEC_MAX) && !w_set && !w_start;

  function automatic logic [3:0][3:0] bcd_dec(input logic [3:0][3:0] v);
    logic [3:0][3:0] d;
    d = v;
    if (v[0] != 4'd0) d[0] = v[0] - 4'd1;
    else begin
      d[0] = 4'd9;
      if (v[1] != 4'd0) d[1] = v[1] - 4'd1;
      else begin
        d[1] = 4'd5;
        if (v[2] != 4'd0) d[2] = v[2] - 4'd1;
        else begin
          d[2] = 4'd9;
          d[3] = (v[3] != 4'd0) ? v[3] - 4'd1 : 4'd9;
        end
      end
    end
    return d;
  endfunction

  function automatic logic [3:0] dig_inc(input logic [3:0] d, input logic [3:0] mx);
    return (d >= mx) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] dig_dec(input logic [3:0] d, input logic [3:0] mx);
    return (d == 4'd0) ? mx : d - 4'd1;
  endfunction

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_set)                     w_next_state = EDIT;
        else if (w_start && !w_p_zero) w_next_state = RUN;
      end
      EDIT: begin
        if (w_set)        w_next_state = IDLE;
        else if (w_start) w_next_state = w_p_zero ? IDLE : RUN;
      end
      RUN: begin
        if (w_set)                  w_next_state = IDLE;
        else if (w_start)           w_next_state = PAUSE;
        else if (w_tick && w_c_one) w_next_state = DONE;
      end
      PAUSE: begin
        if (w_set)        w_next_state = IDLE;
        else if (w_start) w_next_state = RUN;
      end
      DONE: begin
        if (w_any) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_p   <= 16'h0100;
      r_c   <= '0;
      r_sel <= '0;
    end else begin
      if (r_state == IDLE && w_set)      r_sel <= '0;
      else if (r_state == EDIT && w_next) r_sel <= r_sel + 2'd1;

      if (r_state == EDIT && w_up)        r_p[r_sel] <= dig_inc(r_p[r_sel], w_max);
      else if (r_state == EDIT && w_down) r_p[r_sel] <= dig_dec(r_p[r_sel], w_max);

      if (w_load)      r_c <= r_p;
      else if (w_tick) r_c <= bcd_dec(r_c);
    end
  end

  // Sec counter runs only in RUN and keeps its remainder across PAUSE.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_sec <= '0;
    end else if (w_load) begin
      r_sec <= '0;
    end else if (r_state == RUN) begin
      if (r_sec != SEC_MAX)             r_sec <= r_sec + 1'b1;
      else if (!w_set && !w_start)      r_sec <= '0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_blk   <= '0;
      r_phase <= 1'b1;
    end else if (r_blk == BLK_MAX) begin
      r_blk   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_blk <= r_blk + 1'b1;
    end
  end

  always_comb begin
    state_o   = r_state;
    alarm     = (r_state == DONE);
    ONES      = r_p[0];
    TENS      = r_p[1];
    HUNDREDS  = r_p[2];
    THOUSANDS = r_p[3];
    blink_o   = 1'b1;
    blink_t   = 1'b1;
    blink_h   = 1'b1;
    blink_th  = 1'b1;
    if (r_state == RUN || r_state == PAUSE || r_state == DONE) begin
      ONES      = r_c[0];
      TENS      = r_c[1];
      HUNDREDS  = r_c[2];
      THOUSANDS = r_c[3];
    end
    if (r_state == EDIT) begin
      blink_o  = (r_sel == 2'd0) ? r_phase : 1'b1;
      blink_t  = (r_sel == 2'd1) ? r_phase : 1'b1;
      blink_h  = (r_sel == 2'd2) ? r_phase : 1'b1;
      blink_th = (r_sel == 2'd3) ? r_phase : 1'b1;
    end else if (r_state == PAUSE || r_state == DONE) begin
      blink_o  = r_phase;
      blink_t  = r_phase;
      blink_h  = r_phase;
      blink_th = r_phase;
    end
  end

endmodule

// File: tb/tb_timer_disp_ctrl.sv
// Directed bench for timer_disp_ctrl with SEC_DIV=10, BLINK_DIV=4.
module tb_timer_disp_ctrl;

  logic       clk, clr;
  logic       btn_set, btn_start, btn_next, btn_up, btn_down;
  logic [3:0] ONES, TENS, HUNDREDS, THOUSANDS;
  logic       blink_o, blink_t, blink_h, blink_th, alarm;
  logic [2:0] state_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc;

  localparam logic [4:0] B_SET   = 5'b10000;
  localparam logic [4:0] B_START = 5'b01000;
  localparam logic [4:0] B_NEXT  = 5'b00100;
  localparam logic [4:0] B_UP    = 5'b00010;
  localparam logic [4:0] B_DOWN  = 5'b00001;

  timer_disp_ctrl #(.SEC_DIV(10), .BLINK_DIV(4)) dut (
    .clk(clk), .clr(clr),
    .btn_set(btn_set), .btn_start(btn_start), .btn_next(btn_next),
    .btn_up(btn_up), .btn_down(btn_down),
    .ONES(ONES), .TENS(TENS), .HUNDREDS(HUNDREDS), .THOUSANDS(THOUSANDS),
    .blink_o(blink_o), .blink_t(blink_t), .blink_h(blink_h), .blink_th(blink_th),
    .alarm(alarm), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since clr release; expected blink phase is 1 ^ bit 2.
  always @(posedge clk or posedge clr) begin
    if (clr) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic exp_phase();
    return ~cyc[2];
  endfunction

  function automatic logic [15:0] digits();
    return {THOUSANDS, HUNDREDS, TENS, ONES};
  endfunction

  function automatic logic [15:0] enables();
    return {12'h0, blink_th, blink_h, blink_t, blink_o};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [4:0] b);
    {btn_set, btn_start, btn_next, btn_up, btn_down} = b;
    @(negedge clk);
    {btn_set, btn_start, btn_next, btn_up, btn_down} = '0;
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    {btn_set, btn_start, btn_next, btn_up, btn_down} = '0;
    clr = 1'b1;
    wait_cyc(2);
    clr = 1'b0;
  endtask

  // From reset preset 01:00, edit to 00:10 and leave the block in EDIT.
  task automatic make_p_0010();
    press(B_SET);
    press(B_NEXT);
    press(B_UP);
    press(B_NEXT);
    press(B_DOWN);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset values
    do_reset();
    check("rst_digits", digits(), 16'h0100);
    check("rst_state", 16'(state_o), 16'd0);
    check("rst_enables", enables(), 16'h000F);
    check("rst_alarm", 16'(alarm), 16'd0);

    // 2. edit wrap on TENS, blink follows phase
    press(B_SET);
    check("edit_enter", 16'(state_o), 16'd1);
    press(B_NEXT);
    repeat (5) press(B_UP);
    check("edit_tens5", 16'(TENS), 16'd5);
    press(B_UP);
    check("edit_tens_wrap", 16'(TENS), 16'd0);
    for (int unsigned i = 0; i < 8; i++) begin
      check("edit_blink_t", enables(), {12'h0, 3'b111, 1'b1} & {12'h0, 1'b1, 1'b1, exp_phase(), 1'b1});
      wait_cyc(1);
    end
    press(B_DOWN);
    check("edit_tens_down_wrap", 16'(TENS), 16'd5);
    repeat (3) press(B_NEXT);
    for (int unsigned i = 0; i < 4; i++) begin
      check("edit_blink_o", enables(), {12'h0, 3'b111, exp_phase()});
      wait_cyc(1);
    end
    press(B_NEXT);
    press(B_UP);
    check("edit_sel_back_tens", digits(), 16'h0100);

    // 3. countdown 00:10 to DONE
    do_reset();
    make_p_0010();
    check("p_0010", digits(), 16'h0010);
    press(B_START);
    check("run_state", 16'(state_o), 16'd2);
    check("run_load", digits(), 16'h0010);
    wait_cyc(9);
    check("run_before_tick", digits(), 16'h0010);
    wait_cyc(1);
    check("run_first_tick", digits(), 16'h0009);
    wait_cyc(89);
    check("run_last_sec", digits(), 16'h0001);
    check("run_last_state", 16'(state_o), 16'd2);
    wait_cyc(1);
    check("done_state", 16'(state_o), 16'd4);
    check("done_digits", digits(), 16'h0000);
    check("done_alarm", 16'(alarm), 16'd1);
    for (int unsigned i = 0; i < 4; i++) begin
      check("done_blink", enables(), {12'h0, {4{exp_phase()}}});
      wait_cyc(1);
    end
    press(B_UP);
    check("done_exit_state", 16'(state_o), 16'd0);
    check("done_exit_alarm", 16'(alarm), 16'd0);
    check("done_exit_digits", digits(), 16'h0010);

    // 4. borrow chain 10:00 -> 09:59
    do_reset();
    press(B_SET);
    press(B_NEXT);
    press(B_NEXT);
    press(B_DOWN);
    press(B_NEXT);
    press(B_UP);
    check("p_1000", digits(), 16'h1000);
    press(B_START);
    wait_cyc(10);
    check("borrow_0959", digits(), 16'h0959);

    // 5. pause / resume keeps the sub-second remainder
    do_reset();
    make_p_0010();
    press(B_START);
    wait_cyc(12);
    press(B_START);
    check("pause_state", 16'(state_o), 16'd3);
    check("pause_digits", digits(), 16'h0009);
    wait_cyc(10);
    check("pause_frozen", digits(), 16'h0009);
    check("pause_blink", enables(), {12'h0, {4{exp_phase()}}});
    wait_cyc(9);
    press(B_START);
    check("resume_state", 16'(state_o), 16'd2);
    wait_cyc(6);
    check("resume_hold", digits(), 16'h0009);
    wait_cyc(1);
    check("resume_tick7", digits(), 16'h0008);

    // 6. edge cases
    do_reset();
    press(B_SET);
    press(B_NEXT);
    press(B_NEXT);
    press(B_DOWN);
    press(B_SET);
    press(B_START);
    check("zero_start_state", 16'(state_o), 16'd0);
    check("zero_start_digits", digits(), 16'h0000);
    press(B_SET);
    press(B_SET | B_START);
    check("set_start_state", 16'(state_o), 16'd0);
    press(B_SET);
    press(B_UP);
    press(B_START);
    check("p1_run_state", 16'(state_o), 16'd2);
    wait_cyc(5);
    #2 clr = 1'b1;
    #1;
    check("clr_state", 16'(state_o), 16'd0);
    check("clr_digits", digits(), 16'h0100);
    check("clr_enables", enables(), 16'h000F);
    check("clr_alarm", 16'(alarm), 16'd0);
    @(negedge clk);
    clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
